ysyx_22040237_mem_arb: RTL and testbench

YSYX_22040237_MEM_ARB -- requirements
Module: ysyx_22040237_mem_arb

---
 rtl/ysyx_22040237_mem_arb_pkg.sv | 30 +++
 rtl/ysyx_22040237_mem_arb.sv | 158 +++++++++++++++
 tb/tb_ysyx_22040237_mem_arb.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040237_mem_arb_pkg.sv
// Shared definitions for the IFU/LSU memory arbiter: FSM state encoding,
// owner encoding and the arbitration rule used in IDLE.
package ysyx_22040237_mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_e;

  // A lone requester always wins; under contention the side that was not
  // served last wins, so IFU and LSU alternate.
  function automatic arb_owner_e pick_owner(input logic       ifu_req,
                                            input logic       lsu_req,
                                            input arb_owner_e last_owner);
    if (ifu_req && lsu_req) begin
      return (last_owner == OWN_IFU) ? OWN_LSU : OWN_IFU;
    end else if (lsu_req) begin
      return OWN_LSU;
    end else begin
      return OWN_IFU;
    end
  endfunction

endpackage

// File: rtl/ysyx_22040237_mem_arb.sv
// ysyx_22040237_mem_arb: shares one memory port between the instruction
// fetch unit and the load/store unit, one transaction in flight at a time.
// Optional watchdog: define YSYX_22040237_MEM_ARB_TIMEOUT_EN to add the
// TIMEOUT_CYC cycle watchdog and the sticky timeout_o port.
module ysyx_22040237_mem_arb
  import ysyx_22040237_mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_i,
  input  logic [ADDR_W-1:0]   ifu_addr_i,
  output logic                ifu_gnt_o,
  output logic                ifu_rvalid_o,
  output logic [DATA_W-1:0]   ifu_rdata_o,
  input  logic                lsu_req_i,
  input  logic                lsu_we_i,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic [DATA_W-1:0]   lsu_wdata_i,
  input  logic [DATA_W/8-1:0] lsu_wmask_i,
  output logic                lsu_gnt_o,
  output logic                lsu_rvalid_o,
  output logic [DATA_W-1:0]   lsu_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wmask_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                busy_o
`ifdef YSYX_22040237_MEM_ARB_TIMEOUT_EN
  ,
  output logic                timeout_o
`endif
);

  if (((DATA_W % 8) != 0) || (TIMEOUT_CYC < 1)) begin : g_param_check
    $error("ysyx_22040237_mem_arb: DATA_W must be a multiple of 8 and TIMEOUT_CYC at least 1");
  end

  arb_state_e          state_q;
  arb_owner_e          owner_q;
  arb_owner_e          last_owner_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wmask_q;

  arb_owner_e          selOwner;
  logic                timeoutHit;
  logic                gntFire;
  logic                rvalidFire;
  logic [DATA_W-1:0]   respData;

  assign selOwner = pick_owner(ifu_req_i, lsu_req_i, last_owner_q);

`ifdef YSYX_22040237_MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;

  assign timeoutHit = (state_q != ST_IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign timeout_o  = timeout_q;

  // Watchdog: count cycles spent in REQ/RESP, restart from zero in IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (timeoutHit) begin
        timeout_q <= 1'b1;
      end
    end
  end
`else
  assign timeoutHit = 1'b0;
`endif

  // Arbitration FSM: pick and latch a transaction in IDLE, present it in REQ,
  // wait for the response in RESP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_IFU;
      last_owner_q <= OWN_IFU;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (ifu_req_i || lsu_req_i) begin
            owner_q <= selOwner;
            state_q <= ST_REQ;
            if (selOwner == OWN_LSU) begin
              we_q    <= lsu_we_i;
              addr_q  <= lsu_addr_i;
              wdata_q <= lsu_wdata_i;
              wmask_q <= lsu_wmask_i;
            end else begin
              we_q    <= 1'b0;
              addr_q  <= ifu_addr_i;
              wdata_q <= '0;
              wmask_q <= '0;
            end
          end
        end
        ST_REQ: begin
          if (timeoutHit) begin
            state_q      <= ST_IDLE;
            last_owner_q <= owner_q;
          end else if (mem_gnt_i) begin
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (mem_rvalid_i || timeoutHit) begin
            state_q      <= ST_IDLE;
            last_owner_q <= owner_q;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign mem_req_o   = (state_q == ST_REQ);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wmask_o = wmask_q;

  assign gntFire    = (state_q == ST_REQ) && (mem_gnt_i || timeoutHit);
  assign rvalidFire = ((state_q == ST_RESP) && mem_rvalid_i) || timeoutHit;
  assign respData   = ((state_q == ST_RESP) && mem_rvalid_i) ? mem_rdata_i : '0;

  assign ifu_gnt_o    = gntFire && (owner_q == OWN_IFU);
  assign lsu_gnt_o    = gntFire && (owner_q == OWN_LSU);
  assign ifu_rvalid_o = rvalidFire && (owner_q == OWN_IFU);
  assign lsu_rvalid_o = rvalidFire && (owner_q == OWN_LSU);
  assign ifu_rdata_o  = ifu_rvalid_o ? respData : '0;
  assign lsu_rdata_o  = lsu_rvalid_o ? respData : '0;

endmodule

// File: tb/tb_ysyx_22040237_mem_arb.sv
// Self-checking bench for ysyx_22040237_mem_arb. The bench plays both
// requesters and the memory; a transaction-level model predicts the winner,
// the payload on the memory port and where each grant and response lands.
// Define YSYX_22040237_MEM_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_ysyx_22040237_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_i;
  logic [63:0] ifu_addr_i;
  logic        ifu_gnt_o;
  logic        ifu_rvalid_o;
  logic [63:0] ifu_rdata_o;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [63:0] lsu_addr_i;
  logic [63:0] lsu_wdata_i;
  logic [7:0]  lsu_wmask_i;
  logic        lsu_gnt_o;
  logic        lsu_rvalid_o;
  logic [63:0] lsu_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [63:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic [7:0]  mem_wmask_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [63:0] mem_rdata_i;
  logic        busy_o;
`ifdef YSYX_22040237_MEM_ARB_TIMEOUT_EN
  logic        timeout_o;
`endif

  int   errors = 0;
  int   checks = 0;
  logic lastOwner;
  logic holdIfu;
  logic holdLsu;

  ysyx_22040237_mem_arb #(
    .ADDR_W     (64),
    .DATA_W     (64)
`ifdef YSYX_22040237_MEM_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(8)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ifu_req_i   (ifu_req_i),
    .ifu_addr_i  (ifu_addr_i),
    .ifu_gnt_o   (ifu_gnt_o),
    .ifu_rvalid_o(ifu_rvalid_o),
    .ifu_rdata_o (ifu_rdata_o),
    .lsu_req_i   (lsu_req_i),
    .lsu_we_i    (lsu_we_i),
    .lsu_addr_i  (lsu_addr_i),
    .lsu_wdata_i (lsu_wdata_i),
    .lsu_wmask_i (lsu_wmask_i),
    .lsu_gnt_o   (lsu_gnt_o),
    .lsu_rvalid_o(lsu_rvalid_o),
    .lsu_rdata_o (lsu_rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_wmask_o (mem_wmask_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i (mem_rdata_i),
    .busy_o      (busy_o)
`ifdef YSYX_22040237_MEM_ARB_TIMEOUT_EN
    ,
    .timeout_o   (timeout_o)
`endif
  );

  always #5 clk = ~clk;

  // Hard stop in case the sequence below ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ifuR, input logic lsuR, input logic mGnt,
                               input logic mRv, input logic [63:0] mData);
    ifu_req_i    = ifuR;
    lsu_req_i    = lsuR;
    mem_gnt_i    = mGnt;
    mem_rvalid_i = mRv;
    mem_rdata_i  = mData;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction starting from an IDLE cycle.
  task automatic runTxn(input logic ifuR, input logic lsuR, input logic we,
                        input logic [63:0] iAddr, input logic [63:0] lAddr,
                        input logic [63:0] lData, input logic [7:0] lMask,
                        input logic [63:0] rData, input int gDly, input int rDly,
                        input logic dropEarly);
    logic        expOwn;
    logic [63:0] expAddr;
    logic        expWe;
    logic [7:0]  expMask;
    if (ifuR && lsuR) expOwn = ~lastOwner;
    else              expOwn = lsuR;
    if (expOwn) begin
      expAddr = lAddr; expWe = we; expMask = lMask;
    end else begin
      expAddr = iAddr; expWe = 1'b0; expMask = 8'h00;
    end

    tick();
    ifu_addr_i  = iAddr;
    lsu_addr_i  = lAddr;
    lsu_we_i    = we;
    lsu_wdata_i = lData;
    lsu_wmask_i = lMask;
    applyStimulus(ifuR, lsuR, 1'b0, 1'b1, {$urandom, $urandom});
    #1;
    checkOutput("idle_busy",    64'(busy_o), 64'(0));
    checkOutput("idle_mem_req", 64'(mem_req_o), 64'(0));
    checkOutput("idle_gnt",     64'({ifu_gnt_o, lsu_gnt_o}), 64'(0));
    checkOutput("idle_rvalid",  64'({ifu_rvalid_o, lsu_rvalid_o}), 64'(0));

    for (int c = 0; c <= gDly; c++) begin
      tick();
      if (dropEarly) begin
        if (expOwn) lsuR = 1'b0;
        else        ifuR = 1'b0;
      end
      applyStimulus(ifuR, lsuR, 1'(c == gDly), 1'($urandom_range(0, 1)), {$urandom, $urandom});
      #1;
      checkOutput("req_mem_req", 64'(mem_req_o), 64'(1));
      checkOutput("req_busy",    64'(busy_o), 64'(1));
      checkOutput("req_addr",    mem_addr_o, expAddr);
      checkOutput("req_we",      64'(mem_we_o), 64'(expWe));
      checkOutput("req_wmask",   64'(mem_wmask_o), 64'(expMask));
      if (expOwn) checkOutput("req_wdata", mem_wdata_o, lData);
      checkOutput("req_ifu_gnt", 64'(ifu_gnt_o), 64'((c == gDly) && !expOwn));
      checkOutput("req_lsu_gnt", 64'(lsu_gnt_o), 64'((c == gDly) && expOwn));
      checkOutput("req_rvalid",  64'({ifu_rvalid_o, lsu_rvalid_o}), 64'(0));
    end

    if (expOwn) lsuR = 1'b0;
    else        ifuR = 1'b0;

    for (int c = 0; c <= rDly; c++) begin
      tick();
      applyStimulus(ifuR, lsuR, 1'($urandom_range(0, 1)), 1'(c == rDly),
                    (c == rDly) ? rData : {$urandom, $urandom});
      #1;
      checkOutput("resp_mem_req",    64'(mem_req_o), 64'(0));
      checkOutput("resp_busy",       64'(busy_o), 64'(1));
      checkOutput("resp_gnt",        64'({ifu_gnt_o, lsu_gnt_o}), 64'(0));
      checkOutput("resp_ifu_rvalid", 64'(ifu_rvalid_o), 64'((c == rDly) && !expOwn));
      checkOutput("resp_lsu_rvalid", 64'(lsu_rvalid_o), 64'((c == rDly) && expOwn));
      checkOutput("resp_ifu_rdata",  ifu_rdata_o, ((c == rDly) && !expOwn) ? rData : 64'(0));
      checkOutput("resp_lsu_rdata",  lsu_rdata_o, ((c == rDly) && expOwn) ? rData : 64'(0));
    end

    lastOwner = expOwn;
    holdIfu   = ifuR;
    holdLsu   = lsuR;
  endtask

`ifdef YSYX_22040237_MEM_ARB_TIMEOUT_EN
  // IFU request that memory never answers; the watchdog must finish it.
  task automatic runTimeout();
    tick();
    ifu_addr_i = {$urandom, $urandom};
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 64'(0));
    #1;
    checkOutput("to_idle_busy", 64'(busy_o), 64'(0));
    for (int c = 1; c <= 8; c++) begin
      tick();
      applyStimulus(1'(c < 8), 1'b0, 1'b0, 1'b0, {$urandom, $urandom} | 64'(1));
      #1;
      checkOutput("to_ifu_gnt",    64'(ifu_gnt_o), 64'(c == 8));
      checkOutput("to_ifu_rvalid", 64'(ifu_rvalid_o), 64'(c == 8));
      checkOutput("to_ifu_rdata",  ifu_rdata_o, 64'(0));
      checkOutput("to_lsu_rvalid", 64'(lsu_rvalid_o), 64'(0));
      checkOutput("to_flag_early", 64'(timeout_o), 64'(0));
    end
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'(0));
    #1;
    checkOutput("to_after_busy", 64'(busy_o), 64'(0));
    checkOutput("to_flag_set",   64'(timeout_o), 64'(1));
    lastOwner = 1'b0;
    holdIfu   = 1'b0;
    holdLsu   = 1'b0;
  endtask
`endif

  initial begin
    rst         = 1'b0;
    lastOwner   = 1'b0;
    holdIfu     = 1'b0;
    holdLsu     = 1'b0;
    ifu_addr_i  = '0;
    lsu_we_i    = 1'b0;
    lsu_addr_i  = '0;
    lsu_wdata_i = '0;
    lsu_wmask_i = '0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'(0));

    // Reset values
    #12;
    checkOutput("rst_busy",    64'(busy_o), 64'(0));
    checkOutput("rst_mem_req", 64'(mem_req_o), 64'(0));
    checkOutput("rst_mem_addr", mem_addr_o, 64'(0));
    checkOutput("rst_mem_wm",  64'({mem_we_o, mem_wmask_o}), 64'(0));
    checkOutput("rst_gnt",     64'({ifu_gnt_o, lsu_gnt_o}), 64'(0));
    checkOutput("rst_rvalid",  64'({ifu_rvalid_o, lsu_rvalid_o}), 64'(0));
`ifdef YSYX_22040237_MEM_ARB_TIMEOUT_EN
    checkOutput("rst_timeout", 64'(timeout_o), 64'(0));
`endif
    tick();
    rst = 1'b1;

    $display("[TB] directed: IFU fetch with immediate grant");
    runTxn(1'b1, 1'b0, 1'b0, 64'h8000_0000, 64'h0, 64'h0, 8'h00, 64'h13, 0, 0, 1'b0);

    $display("[TB] directed: contention alternation");
    lastOwner = 1'b0;
    runTxn(1'b1, 1'b1, 1'b0, 64'h8000_0004, 64'h8000_2000, 64'h0, 8'h00, 64'h1111, 0, 1, 1'b0);
    runTxn(holdIfu, holdLsu, 1'b0, 64'h8000_0004, 64'h0, 64'h0, 8'h00, 64'h2222, 1, 0, 1'b0);
    runTxn(1'b1, 1'b1, 1'b1, 64'h8000_0008, 64'h8000_2008, 64'h55AA, 8'hFF, 64'h0, 0, 0, 1'b0);
    runTxn(holdIfu, holdLsu, 1'b0, 64'h8000_0008, 64'h0, 64'h0, 8'h00, 64'h3333, 0, 2, 1'b0);

    $display("[TB] directed: LSU store with delayed grant");
    runTxn(1'b0, 1'b1, 1'b1, 64'h0, 64'h8000_1000, 64'hDEAD_BEEF, 8'h0F, 64'h0, 3, 1, 1'b1);

    $display("[TB] random traffic");
    for (int t = 0; t < 30; t++) begin : rand_loop
      logic ir;
      logic lr;
      ir = holdIfu | 1'($urandom_range(0, 1));
      lr = holdLsu | 1'($urandom_range(0, 1));
      if (!ir && !lr) begin
        if ($urandom_range(0, 1) == 1) ir = 1'b1;
        else                           lr = 1'b1;
      end
      runTxn(ir, lr, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
             {$urandom, $urandom}, 8'($urandom), {$urandom, $urandom},
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] reset in the middle of a transaction");
    tick();
    lsu_addr_i = 64'h8000_3000;
    lsu_we_i   = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 64'(0));
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 64'(0));
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'(0));
    #1;
    checkOutput("mid_busy", 64'(busy_o), 64'(1));
    #2;
    rst = 1'b0;
    #1;
    checkOutput("arst_busy",    64'(busy_o), 64'(0));
    checkOutput("arst_mem_req", 64'(mem_req_o), 64'(0));
    checkOutput("arst_addr",    mem_addr_o, 64'(0));
    tick();
    tick();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 64'hCAFE_F00D);
    #1;
    checkOutput("post_rst_rvalid", 64'({ifu_rvalid_o, lsu_rvalid_o}), 64'(0));
    checkOutput("post_rst_rdata",  lsu_rdata_o, 64'(0));
    checkOutput("post_rst_busy",   64'(busy_o), 64'(0));
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'(0));
    #1;
    checkOutput("post_rst_idle", 64'(busy_o), 64'(0));
    lastOwner = 1'b0;
    holdIfu   = 1'b0;
    holdLsu   = 1'b0;
    runTxn(1'b1, 1'b1, 1'b0, 64'h8000_0010, 64'h8000_4000, 64'h0, 8'h00, 64'h4444, 0, 0, 1'b0);
    runTxn(holdIfu, holdLsu, 1'b0, 64'h8000_0010, 64'h0, 64'h0, 8'h00, 64'h5555, 0, 0, 1'b0);

`ifdef YSYX_22040237_MEM_ARB_TIMEOUT_EN
    $display("[TB] watchdog timeout");
    runTimeout();
    runTxn(1'b0, 1'b1, 1'b0, 64'h0, 64'h8000_5000, 64'h0, 8'h00, 64'h6666, 1, 1, 1'b0);
    checkOutput("to_sticky", 64'(timeout_o), 64'(1));
`endif

    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'(0));
    #1;
    checkOutput("final_idle", 64'(busy_o), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
